// File: rtl/accel_core_pkg.sv
// accel_core_pkg: shared AXI response codes and read-responder state encoding
package accel_core_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {ST_IDLE, ST_BURST} rd_state_t;
endpackage

// File: rtl/accel_mem_sdp_ram.sv
// accel_mem_sdp_ram: one write port, one registered read-first read port
module accel_mem_sdp_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  assign o_rdata = r_rdata;
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/accel_mem_rd_resp.sv
// accel_mem_rd_resp: AXI INCR read responder over a preloadable RAM with a 2-entry output skid
module accel_mem_rd_resp
  import accel_core_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W = 4,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                         stream_clk,
  input  logic                         stream_rst,
  input  logic [ID_W-1:0]              s_arid,
  input  logic [ADDR_W-1:0]            s_araddr,
  input  logic [7:0]                   s_arlen,
  input  logic                         s_arvalid,
  output logic                         s_arready,
  output logic [ID_W-1:0]              s_rid,
  output logic [DATA_W-1:0]            s_rdata,
  output logic [1:0]                   s_rresp,
  output logic                         s_rlast,
  output logic                         s_rvalid,
  input  logic                         s_rready,
  input  logic                         pre_wr_en,
  input  logic [$clog2(MEM_DEPTH)-1:0] pre_wr_addr,
  input  logic [DATA_W-1:0]            pre_wr_data
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int BW = $clog2(DATA_W / 8);
  rd_state_t r_state, w_state_nxt;
  logic [ID_W-1:0] r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [8:0] r_left;
  logic r_inf, r_inf_last, r_inf_err;
  logic [1:0] r_cnt;
  logic [DATA_W-1:0] r_q_data [2];
  logic [1:0] r_q_resp [2];
  logic r_q_last [2];
  logic [DATA_W-1:0] w_ram_dout, w_inf_data;
  logic [1:0] w_inf_resp, w_cnt_after;
  logic w_ar_hs, w_r_hs, w_fetch, w_pop_q, w_push, w_valid, w_head_last;
  assign s_arready = !stream_rst && r_state == ST_IDLE;
  assign w_ar_hs = s_arvalid && s_arready;
  assign w_valid = r_cnt != 2'd0 || r_inf;
  assign w_r_hs = w_valid && s_rready;
  assign w_fetch = r_state == ST_BURST && r_left != 9'd0 && (r_cnt + {1'b0, r_inf}) <= 2'd1;
  assign w_inf_data = r_inf_err ? '0 : w_ram_dout;
  assign w_inf_resp = r_inf_err ? RESP_SLVERR : RESP_OKAY;
  assign w_pop_q = w_r_hs && r_cnt != 2'd0;
  assign w_push = r_inf && !(w_r_hs && r_cnt == 2'd0);
  assign w_cnt_after = r_cnt - {1'b0, w_pop_q};
  assign w_head_last = r_cnt != 2'd0 ? r_q_last[0] : r_inf_last;
  assign s_rvalid = !stream_rst && w_valid;
  assign s_rlast = !stream_rst && w_valid && w_head_last;
  assign s_rid = stream_rst ? '0 : r_id;
  assign s_rresp = stream_rst ? '0 : (r_cnt != 2'd0 ? r_q_resp[0] : w_inf_resp);
  assign s_rdata = stream_rst ? '0 : (r_cnt != 2'd0 ? r_q_data[0] : w_inf_data);
  always_ff @(posedge stream_clk) r_state <= stream_rst ? ST_IDLE : w_state_nxt;
  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = (r_state == ST_IDLE && w_ar_hs) ? ST_BURST :
                  (r_state == ST_BURST && w_r_hs && w_head_last) ? ST_IDLE : r_state;
  end
  always_ff @(posedge stream_clk) begin
    if (stream_rst) begin
      r_id <= '0;
      r_addr <= '0;
      r_left <= '0;
      r_inf <= 1'b0;
      r_inf_last <= 1'b0;
      r_inf_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (w_ar_hs) begin
        r_id <= s_arid;
        r_addr <= s_araddr >> BW;
        r_left <= {1'b0, s_arlen} + 9'd1;
      end else if (w_fetch) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_left <= r_left - 9'd1;
      end
      r_inf <= w_fetch;
      if (w_fetch) begin
        r_inf_last <= r_left == 9'd1;
        r_inf_err <= r_addr >= ADDR_W'(MEM_DEPTH);
      end
      if (w_pop_q) begin
        r_q_data[0] <= r_q_data[1];
        r_q_resp[0] <= r_q_resp[1];
        r_q_last[0] <= r_q_last[1];
      end
      if (w_push) begin
        r_q_data[w_cnt_after[0]] <= w_inf_data;
        r_q_resp[w_cnt_after[0]] <= w_inf_resp;
        r_q_last[w_cnt_after[0]] <= r_inf_last;
      end
      r_cnt <= w_cnt_after + {1'b0, w_push};
    end
  end
  accel_mem_sdp_ram #(.DATA_W(DATA_W), .DEPTH(MEM_DEPTH)) u_ram (
    .clk(stream_clk),
    .i_we(pre_wr_en),
    .i_waddr(pre_wr_addr),
    .i_wdata(pre_wr_data),
    .i_re(w_fetch),
    .i_raddr(r_addr[AW-1:0]),
    .o_rdata(w_ram_dout)
  );
endmodule

// File: tb/tb_accel_mem_rd_resp.sv
// tb_accel_mem_rd_resp: directed and randomized bursts checked against a word-array reference model
module tb_accel_mem_rd_resp;
  logic stream_clk = 1'b0;
  logic stream_rst = 1'b1;
  logic [3:0] s_arid = '0;
  logic [31:0] s_araddr = '0;
  logic [7:0] s_arlen = '0;
  logic s_arvalid = 1'b0;
  logic s_arready;
  logic [3:0] s_rid;
  logic [63:0] s_rdata;
  logic [1:0] s_rresp;
  logic s_rlast, s_rvalid;
  logic s_rready = 1'b0;
  logic pre_wr_en = 1'b0;
  logic [9:0] pre_wr_addr = '0;
  logic [63:0] pre_wr_data = '0;
  always #5 stream_clk = ~stream_clk;
  accel_mem_rd_resp dut (
    .stream_clk(stream_clk), .stream_rst(stream_rst),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .pre_wr_en(pre_wr_en), .pre_wr_addr(pre_wr_addr), .pre_wr_data(pre_wr_data)
  );
  int errs = 0;
  int checks = 0;
  logic [63:0] model [1024];
  logic [63:0] q_data [$];
  logic [1:0] q_resp [$];
  logic [3:0] q_id [$];
  logic q_last [$];
  int pat [$];
  int ar_cyc, first_lat, done_cyc, stall_bad, ar_extra, rv_in_rst;
  function automatic logic [70:0] exp_beat(input logic [31:0] addr, input int len, input logic [3:0] id, input int b);
    longint unsigned w;
    w = 64'(addr >> 3) + 64'(b);
    return {id, (w < 1024) ? 2'b00 : 2'b10, b == len, (w < 1024) ? model[int'(w)] : 64'd0};
  endfunction
  task automatic preload(input int a, input logic [63:0] d);
    @(negedge stream_clk);
    pre_wr_en = 1'b1;
    pre_wr_addr = 10'(a);
    pre_wr_data = d;
    model[a] = d;
    @(negedge stream_clk);
    pre_wr_en = 1'b0;
  endtask
  task automatic preload_all();
    for (int w = 0; w < 1024; w++) begin
      @(negedge stream_clk);
      pre_wr_en = 1'b1;
      pre_wr_addr = 10'(w);
      pre_wr_data = {$urandom, $urandom};
      model[w] = pre_wr_data;
    end
    @(negedge stream_clk);
    pre_wr_en = 1'b0;
  endtask
  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input int mode,
                           input int hold_id, input int rst_at, input bit wr0, input int limit);
    logic [71:0] prev;
    logic stalled;
    int beats, rst_cyc, j;
    q_data.delete(); q_resp.delete(); q_id.delete(); q_last.delete();
    ar_cyc = -1; first_lat = -1; done_cyc = -1; stall_bad = 0; ar_extra = 0; rv_in_rst = 0;
    stalled = 1'b0; beats = 0; rst_cyc = -1; prev = '0;
    for (int k = 0; k < limit; k++) begin
      @(negedge stream_clk);
      if (ar_cyc < 0) begin
        s_arvalid = 1'b1; s_arid = id; s_araddr = addr; s_arlen = len;
      end else if (hold_id >= 0) begin
        s_arvalid = 1'b1; s_arid = 4'(hold_id);
      end else s_arvalid = 1'b0;
      pre_wr_en = wr0 && ar_cyc >= 0 && k == ar_cyc + 1;
      pre_wr_addr = '0;
      pre_wr_data = 64'hFF;
      j = k - ar_cyc - 2;
      s_rready = mode == 0 ? 1'b1 :
                 mode == 1 ? (ar_cyc >= 0 && j >= 0 && (j >= pat.size() || pat[j] != 0)) :
                 ($urandom_range(0, 1) == 1);
      stream_rst = rst_at >= 0 && beats == rst_at && rst_cyc < 0;
      if (stream_rst) rst_cyc = k;
      #1;
      if (stream_rst && s_rvalid) rv_in_rst++;
      if (s_arvalid && s_arready) begin
        if (ar_cyc < 0) ar_cyc = k;
        else ar_extra++;
      end
      if (stalled && {s_rvalid, s_rid, s_rresp, s_rlast, s_rdata} !== prev) stall_bad++;
      if (s_rvalid && first_lat < 0) first_lat = k - ar_cyc;
      if (s_rvalid && s_rready) begin
        q_data.push_back(s_rdata); q_resp.push_back(s_rresp); q_id.push_back(s_rid); q_last.push_back(s_rlast);
        beats++;
        if (s_rlast) done_cyc = k;
      end
      stalled = s_rvalid && !s_rready;
      prev = {s_rvalid, s_rid, s_rresp, s_rlast, s_rdata};
      if (done_cyc >= 0) break;
    end
  endtask
  task automatic test_reset();
    stream_rst = 1'b1;
    repeat (3) @(negedge stream_clk);
    #1;
    checks++; if (s_arready !== 1'b0) begin errs++; $display("FAIL reset_arready got=%b exp=0", s_arready); end
    checks++; if (s_rvalid !== 1'b0) begin errs++; $display("FAIL reset_rvalid got=%b exp=0", s_rvalid); end
    checks++;
    if ({s_rlast, s_rdata, s_rid, s_rresp} !== 71'd0) begin
      errs++; $display("FAIL reset_rpayload got=%h exp=0", {s_rlast, s_rdata, s_rid, s_rresp});
    end
    @(negedge stream_clk);
    stream_rst = 1'b0;
    @(negedge stream_clk);
    #1;
    checks++; if (s_arready !== 1'b1) begin errs++; $display("FAIL reset_release_arready got=%b exp=1", s_arready); end
  endtask
  task automatic test_basic();
    for (int w = 0; w < 4; w++) preload(w, 64'hA0 + 64'(w));
    run_burst(4'd5, 32'h0, 8'd3, 0, -1, -1, 1'b0, 200);
    checks++; if (first_lat != 2) begin errs++; $display("FAIL basic_latency got=%0d exp=2", first_lat); end
    checks++; if (q_data.size() != 4) begin errs++; $display("FAIL basic_count got=%0d exp=4", q_data.size()); end
    checks++; if (done_cyc - ar_cyc != 5) begin errs++; $display("FAIL basic_duration got=%0d exp=5", done_cyc - ar_cyc); end
    for (int b = 0; b < q_data.size() && b < 4; b++) begin
      checks++;
      if ({q_id[b], q_resp[b], q_last[b], q_data[b]} !== {4'd5, 2'b00, b == 3, 64'hA0 + 64'(b)}) begin
        errs++; $display("FAIL basic_beat%0d got=%h exp=%h", b, {q_id[b], q_resp[b], q_last[b], q_data[b]}, {4'd5, 2'b00, b == 3, 64'hA0 + 64'(b)});
      end
    end
    @(negedge stream_clk);
    s_rready = 1'b0;
    #1;
    checks++; if (s_arready !== 1'b1) begin errs++; $display("FAIL basic_arready_after got=%b exp=1", s_arready); end
  endtask
  task automatic test_stall();
    pat = '{1, 0, 0, 1, 0, 1, 1};
    run_burst(4'd5, 32'h0, 8'd3, 1, -1, -1, 1'b0, 200);
    checks++; if (q_data.size() != 4) begin errs++; $display("FAIL stall_count got=%0d exp=4", q_data.size()); end
    checks++; if (stall_bad != 0) begin errs++; $display("FAIL stall_stable got=%0d exp=0", stall_bad); end
    for (int b = 0; b < q_data.size() && b < 4; b++) begin
      checks++;
      if ({q_id[b], q_resp[b], q_last[b], q_data[b]} !== exp_beat(32'h0, 3, 4'd5, b)) begin
        errs++; $display("FAIL stall_beat%0d got=%h exp=%h", b, {q_id[b], q_resp[b], q_last[b], q_data[b]}, exp_beat(32'h0, 3, 4'd5, b));
      end
    end
  endtask
  task automatic test_out_of_range();
    run_burst(4'd2, 32'h1FF0, 8'd3, 0, -1, -1, 1'b0, 200);
    checks++; if (q_data.size() != 4) begin errs++; $display("FAIL oob_count got=%0d exp=4", q_data.size()); end
    for (int b = 0; b < q_data.size() && b < 4; b++) begin
      checks++;
      if ({q_id[b], q_resp[b], q_last[b], q_data[b]} !== exp_beat(32'h1FF0, 3, 4'd2, b)) begin
        errs++; $display("FAIL oob_beat%0d got=%h exp=%h", b, {q_id[b], q_resp[b], q_last[b], q_data[b]}, exp_beat(32'h1FF0, 3, 4'd2, b));
      end
    end
  endtask
  task automatic test_back_to_back();
    run_burst(4'd5, 32'h0, 8'd3, 0, 7, -1, 1'b0, 200);
    checks++; if (ar_extra != 0) begin errs++; $display("FAIL b2b_early_accept got=%0d exp=0", ar_extra); end
    checks++; if (q_data.size() != 4) begin errs++; $display("FAIL b2b_first_count got=%0d exp=4", q_data.size()); end
    run_burst(4'd7, 32'h0, 8'd3, 0, -1, -1, 1'b0, 200);
    checks++; if (ar_cyc != 0) begin errs++; $display("FAIL b2b_accept_cycle got=%0d exp=0", ar_cyc); end
    checks++; if (first_lat != 2) begin errs++; $display("FAIL b2b_latency got=%0d exp=2", first_lat); end
    for (int b = 0; b < q_data.size() && b < 4; b++) begin
      checks++;
      if ({q_id[b], q_resp[b], q_last[b], q_data[b]} !== exp_beat(32'h0, 3, 4'd7, b)) begin
        errs++; $display("FAIL b2b_beat%0d got=%h exp=%h", b, {q_id[b], q_resp[b], q_last[b], q_data[b]}, exp_beat(32'h0, 3, 4'd7, b));
      end
    end
  endtask
  task automatic test_mid_reset();
    run_burst(4'd9, 32'h0, 8'd7, 0, -1, 2, 1'b0, 20);
    checks++; if (q_data.size() != 2) begin errs++; $display("FAIL midrst_count got=%0d exp=2", q_data.size()); end
    checks++; if (rv_in_rst != 0) begin errs++; $display("FAIL midrst_rvalid got=%0d exp=0", rv_in_rst); end
    checks++; if (done_cyc != -1) begin errs++; $display("FAIL midrst_rlast got=%0d exp=-1", done_cyc); end
    for (int b = 0; b < q_data.size() && b < 2; b++) begin
      checks++;
      if ({q_id[b], q_resp[b], q_last[b], q_data[b]} !== exp_beat(32'h0, 7, 4'd9, b)) begin
        errs++; $display("FAIL midrst_beat%0d got=%h exp=%h", b, {q_id[b], q_resp[b], q_last[b], q_data[b]}, exp_beat(32'h0, 7, 4'd9, b));
      end
    end
    @(negedge stream_clk);
    #1;
    checks++; if (s_arready !== 1'b1) begin errs++; $display("FAIL midrst_arready got=%b exp=1", s_arready); end
    run_burst(4'd9, 32'h0, 8'd7, 0, -1, -1, 1'b0, 200);
    checks++; if (q_data.size() != 8) begin errs++; $display("FAIL midrst_reread_count got=%0d exp=8", q_data.size()); end
    for (int b = 0; b < q_data.size() && b < 8; b++) begin
      checks++;
      if ({q_id[b], q_resp[b], q_last[b], q_data[b]} !== exp_beat(32'h0, 7, 4'd9, b)) begin
        errs++; $display("FAIL midrst_reread%0d got=%h exp=%h", b, {q_id[b], q_resp[b], q_last[b], q_data[b]}, exp_beat(32'h0, 7, 4'd9, b));
      end
    end
  endtask
  task automatic test_read_first();
    logic [70:0] e0, e1;
    e0 = exp_beat(32'h0, 1, 4'd3, 0);
    e1 = exp_beat(32'h0, 1, 4'd3, 1);
    run_burst(4'd3, 32'h0, 8'd1, 0, -1, -1, 1'b1, 200);
    model[0] = 64'hFF;
    checks++; if (q_data.size() != 2) begin errs++; $display("FAIL rdfirst_count got=%0d exp=2", q_data.size()); end
    checks++;
    if (q_data.size() < 1 || {q_id[0], q_resp[0], q_last[0], q_data[0]} !== e0) begin
      errs++; $display("FAIL rdfirst_old got=%h exp=%h", q_data.size() > 0 ? q_data[0] : 64'd0, e0[63:0]);
    end
    checks++;
    if (q_data.size() < 2 || {q_id[1], q_resp[1], q_last[1], q_data[1]} !== e1) begin
      errs++; $display("FAIL rdfirst_beat1 got=%h exp=%h", q_data.size() > 1 ? q_data[1] : 64'd0, e1[63:0]);
    end
    run_burst(4'd3, 32'h0, 8'd0, 0, -1, -1, 1'b0, 200);
    checks++;
    if (q_data.size() != 1 || q_data[0] !== 64'hFF) begin
      errs++; $display("FAIL rdfirst_new got=%h exp=ff", q_data.size() > 0 ? q_data[0] : 64'd0);
    end
  endtask
  task automatic test_random();
    logic [3:0] id;
    logic [31:0] a;
    int len;
    for (int n = 0; n < 24; n++) begin
      id = 4'($urandom);
      a = 32'($urandom_range(0, 1100)) << 3;
      len = int'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) preload(int'($urandom_range(0, 1023)), {$urandom, $urandom});
      run_burst(id, a, 8'(len), 2, -1, -1, 1'b0, 200);
      checks++; if (q_data.size() != len + 1) begin errs++; $display("FAIL rand%0d_count got=%0d exp=%0d", n, q_data.size(), len + 1); end
      checks++; if (stall_bad != 0) begin errs++; $display("FAIL rand%0d_stable got=%0d exp=0", n, stall_bad); end
      checks++; if (first_lat != 2) begin errs++; $display("FAIL rand%0d_latency got=%0d exp=2", n, first_lat); end
      for (int b = 0; b < q_data.size() && b <= len; b++) begin
        checks++;
        if ({q_id[b], q_resp[b], q_last[b], q_data[b]} !== exp_beat(a, len, id, b)) begin
          errs++; $display("FAIL rand%0d_beat%0d got=%h exp=%h", n, b, {q_id[b], q_resp[b], q_last[b], q_data[b]}, exp_beat(a, len, id, b));
        end
      end
    end
  endtask
  initial begin
    test_reset();
    preload_all();
    test_basic();
    test_stall();
    test_out_of_range();
    test_back_to_back();
    test_mid_reset();
    test_read_first();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
